// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: ID-stage PC source selects and FSM states.
package pipeline_hazard_ctrl_pkg;

  localparam logic [2:0] PCSRC_PC4 = 3'd0;
  localparam logic [2:0] PCSRC_BR  = 3'd1;
  localparam logic [2:0] PCSRC_J   = 3'd2;
  localparam logic [2:0] PCSRC_JR  = 3'd3;
  localparam logic [2:0] PCSRC_IRQ = 3'd4;
  localparam logic [2:0] PCSRC_EXC = 3'd5;

  localparam int NUM_CNT = 3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STALL2 = 1'b1
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter: synchronous clear wins over increment, holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg <= '0;
    end else if (clr) begin
      q_reg <= '0;
    end else if (inc && !(&q_reg)) begin
      q_reg <= q_reg + 1'b1;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/interrupt-entry control for the 5-stage core, sitting beside the ID stage.
// Outputs are combinational from the FSM state and the current ID/EX view.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic [2:0]       ID_PCSrc,
  input  logic             ID_Kernel,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_WrReg,
  input  logic             EX_BranchTaken,
  input  logic             irq,
  input  logic             clr_cnt,
  output logic             keep_PC,
  output logic             stall_IF2ID,
  output logic             flush_IF2ID,
  output logic             flush_ID2EX,
  output logic             irq_take,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] irq_cnt
);

  state_t state_reg, state_next;
  logic   irq_pend_reg, irq_pend_next;
  logic   irq_q_reg;

  logic ex_dst_valid;
  logic rs_match;
  logic load_use;
  logic jr_dep;
  logic jr_alu;
  logic is_jump;

  assign ex_dst_valid = (EX_WrReg != 5'd0);
  assign rs_match     = (EX_WrReg == ID_Rs);
  assign load_use     = EX_MemRead && ex_dst_valid &&
                        (rs_match || (ID_UsesRt && (EX_WrReg == ID_Rt)));
  assign jr_dep       = (ID_PCSrc == PCSRC_JR) && ex_dst_valid && rs_match;
  assign jr_alu       = jr_dep && EX_RegWrite && !EX_MemRead;
  assign is_jump      = (ID_PCSrc == PCSRC_J) || (ID_PCSrc == PCSRC_JR);

  always_comb begin
    keep_PC     = 1'b0;
    stall_IF2ID = 1'b0;
    flush_IF2ID = 1'b0;
    flush_ID2EX = 1'b0;
    irq_take    = 1'b0;
    state_next  = ST_IDLE;
    if (!reset) begin
      state_next = ST_IDLE;
    end else if (EX_BranchTaken) begin
      flush_IF2ID = 1'b1;
      flush_ID2EX = 1'b1;
    end else if (state_reg == ST_STALL2) begin
      keep_PC     = 1'b1;
      stall_IF2ID = 1'b1;
      flush_ID2EX = 1'b1;
    end else if (load_use || jr_alu) begin
      keep_PC     = 1'b1;
      stall_IF2ID = 1'b1;
      flush_ID2EX = 1'b1;
      // jr on a loaded register needs the load result, two cycles away
      if (load_use && jr_dep) begin
        state_next = ST_STALL2;
      end
    end else if (is_jump) begin
      flush_IF2ID = 1'b1;
    end else if (irq_pend_reg && !ID_Kernel && (ID_PCSrc == PCSRC_PC4)) begin
      irq_take    = 1'b1;
      flush_IF2ID = 1'b1;
    end
  end

  // A new edge arriving in the same cycle as a take keeps the request pending
  assign irq_pend_next = (irq_pend_reg && !irq_take) || (irq && !irq_q_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      irq_pend_reg <= 1'b0;
      irq_q_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      irq_pend_reg <= irq_pend_next;
      irq_q_reg    <= irq;
    end
  end

  logic [NUM_CNT-1:0] cnt_inc;
  logic [CNT_W-1:0]   cnt_q [NUM_CNT];

  assign cnt_inc[0] = keep_PC;
  assign cnt_inc[1] = flush_IF2ID || flush_ID2EX;
  assign cnt_inc[2] = irq_take;

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      sat_counter #(
        .CNT_W(CNT_W)
      ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (cnt_inc[gi]),
        .clr  (clr_cnt),
        .q    (cnt_q[gi])
      );
    end
  endgenerate

  assign stall_cnt = cnt_q[0];
  assign flush_cnt = cnt_q[1];
  assign irq_cnt   = cnt_q[2];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboarded random + directed test of pipeline_hazard_ctrl against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;
  localparam int MAXV = (1 << CW) - 1;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic [2:0] pcsrc;
    logic       kernel;
    logic       memread;
    logic       regwrite;
    logic [4:0] wr;
    logic       bt;
    logic       irq;
    logic       clr;
  } stim_t;

  typedef struct packed {
    logic        keep;
    logic        stall;
    logic        fif;
    logic        fex;
    logic        take;
    logic [31:0] sc;
    logic [31:0] fc;
    logic [31:0] ic;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    ID_Rs, ID_Rt, EX_WrReg;
  logic          ID_UsesRt, ID_Kernel, EX_MemRead, EX_RegWrite, EX_BranchTaken, irq, clr_cnt;
  logic [2:0]    ID_PCSrc;
  logic          keep_PC, stall_IF2ID, flush_IF2ID, flush_ID2EX, irq_take;
  logic [CW-1:0] stall_cnt, flush_cnt, irq_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t exp_q[$];

  // reference model state
  int m_stall_left = 0;
  bit m_pend = 0;
  bit m_prev_irq = 0;
  int m_sc = 0, m_fc = 0, m_ic = 0;

  pipeline_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_PCSrc(ID_PCSrc),
    .ID_Kernel(ID_Kernel), .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
    .EX_WrReg(EX_WrReg), .EX_BranchTaken(EX_BranchTaken), .irq(irq), .clr_cnt(clr_cnt),
    .keep_PC(keep_PC), .stall_IF2ID(stall_IF2ID), .flush_IF2ID(flush_IF2ID),
    .flush_ID2EX(flush_ID2EX), .irq_take(irq_take),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .irq_cnt(irq_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL cyc=%0d %s got=%0d expected=%0d", cyc, nm, got, want);
    end
  endtask

  function automatic int sat_inc(input int v, input bit inc, input bit clr);
    if (clr) return 0;
    if (inc && v < MAXV) return v + 1;
    return v;
  endfunction

  // Apply one cycle of stimulus and queue the response the rules predict for it
  task automatic tick(input stim_t s);
    exp_t e;
    bit rs_hit, rt_hit, lu, jr_on_dst, stall_now, jump;
    @(posedge clk);
    #1;
    reset = s.rst_n; ID_Rs = s.rs; ID_Rt = s.rt; ID_UsesRt = s.uses_rt;
    ID_PCSrc = s.pcsrc; ID_Kernel = s.kernel; EX_MemRead = s.memread;
    EX_RegWrite = s.regwrite; EX_WrReg = s.wr; EX_BranchTaken = s.bt;
    irq = s.irq; clr_cnt = s.clr;
    e = '0;
    if (!s.rst_n) begin
      m_stall_left = 0; m_pend = 0; m_prev_irq = 0;
      m_sc = 0; m_fc = 0; m_ic = 0;
      exp_q.push_back(e);
      return;
    end
    e.sc = 32'(m_sc); e.fc = 32'(m_fc); e.ic = 32'(m_ic);
    rs_hit    = (s.wr != 0) && (s.wr == s.rs);
    rt_hit    = (s.wr != 0) && s.uses_rt && (s.wr == s.rt);
    lu        = s.memread && (rs_hit || rt_hit);
    jr_on_dst = (s.pcsrc == 3) && rs_hit;
    jump      = (s.pcsrc == 2) || (s.pcsrc == 3);
    stall_now = lu || (jr_on_dst && s.regwrite && !s.memread);
    if (s.bt) begin
      e.fif = 1; e.fex = 1; m_stall_left = 0;
    end else if (m_stall_left > 0) begin
      e.keep = 1; e.stall = 1; e.fex = 1; m_stall_left--;
    end else if (stall_now) begin
      e.keep = 1; e.stall = 1; e.fex = 1;
      m_stall_left = (lu && jr_on_dst) ? 1 : 0;
    end else if (jump) begin
      e.fif = 1;
    end else if (m_pend && !s.kernel && s.pcsrc == 0) begin
      e.take = 1; e.fif = 1;
    end
    m_sc = sat_inc(m_sc, e.keep, s.clr);
    m_fc = sat_inc(m_fc, e.fif || e.fex, s.clr);
    m_ic = sat_inc(m_ic, e.take, s.clr);
    m_pend = (m_pend && !e.take) || (s.irq && !m_prev_irq);
    m_prev_irq = s.irq;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a full set of outputs
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        $display("txn %0d: keep=%0d stall=%0d fif=%0d fex=%0d take=%0d sc=%0d fc=%0d ic=%0d",
                 cyc, keep_PC, stall_IF2ID, flush_IF2ID, flush_ID2EX, irq_take,
                 stall_cnt, flush_cnt, irq_cnt);
        chk("keep_PC",     int'(keep_PC),     int'(e.keep));
        chk("stall_IF2ID", int'(stall_IF2ID), int'(e.stall));
        chk("flush_IF2ID", int'(flush_IF2ID), int'(e.fif));
        chk("flush_ID2EX", int'(flush_ID2EX), int'(e.fex));
        chk("irq_take",    int'(irq_take),    int'(e.take));
        chk("stall_cnt",   int'(stall_cnt),   int'(e.sc));
        chk("flush_cnt",   int'(flush_cnt),   int'(e.fc));
        chk("irq_cnt",     int'(irq_cnt),     int'(e.ic));
      end
    end
  end

  initial begin
    stim_t nop, s;
    nop = '0;
    nop.rst_n = 1'b1;
    reset = 0; ID_Rs = 0; ID_Rt = 0; ID_UsesRt = 0; ID_PCSrc = 0; ID_Kernel = 0;
    EX_MemRead = 0; EX_RegWrite = 0; EX_WrReg = 0; EX_BranchTaken = 0; irq = 0; clr_cnt = 0;

    s = nop; s.rst_n = 0;
    tick(s); tick(s);
    tick(nop);

    // load-use on Rs: single stall
    s = nop; s.memread = 1; s.regwrite = 1; s.wr = 8; s.rs = 8;
    tick(s); tick(nop);

    // lw $31 then jr $31: two stalls
    s = nop; s.memread = 1; s.regwrite = 1; s.wr = 31; s.rs = 31; s.pcsrc = 3;
    tick(s); tick(nop); tick(nop);

    // same, but a taken branch cancels the second stall
    tick(s);
    s = nop; s.bt = 1;
    tick(s); tick(nop);

    // irq edge during a branch in ID, taken on the next plain instruction
    s = nop; s.irq = 1; s.pcsrc = 1;
    tick(s);
    s.pcsrc = 0;
    tick(s); tick(s);
    s.irq = 0;
    tick(s);

    // $zero never hazards; kernel mode masks the pending irq
    s = nop; s.memread = 1; s.wr = 0; s.rs = 0;
    tick(s);
    s = nop; s.irq = 1; s.kernel = 1;
    tick(s); tick(s);
    s.irq = 0;
    tick(s); tick(nop);

    // flush counter saturation, then clear
    s = nop; s.pcsrc = 2;
    for (int i = 0; i < 20; i++) tick(s);
    s = nop; s.clr = 1;
    tick(s); tick(nop);

    // reset dropped in the middle of STALL2
    s = nop; s.memread = 1; s.regwrite = 1; s.wr = 31; s.rs = 31; s.pcsrc = 3;
    tick(s);
    s = nop; s.rst_n = 0;
    tick(s);
    tick(nop); tick(nop);

    for (int i = 0; i < 1500; i++) begin
      s.rst_n    = ($urandom_range(0, 199) != 0);
      s.rs       = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.uses_rt  = 1'($urandom_range(0, 1));
      s.pcsrc    = 3'($urandom_range(0, 5));
      s.kernel   = ($urandom_range(0, 3) == 0);
      s.memread  = ($urandom_range(0, 9) < 4);
      s.regwrite = ($urandom_range(0, 9) < 7);
      s.wr       = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
      s.bt       = ($urandom_range(0, 9) == 0);
      s.irq      = ($urandom_range(0, 4) == 0) ? ~irq : irq;
      s.clr      = ($urandom_range(0, 29) == 0);
      tick(s);
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
